// File: rtl/gray_counter.sv
// gray_counter: N-bit up/down counter with registered binary and Gray outputs.
// One binary state register drives both outputs; the Gray register is loaded from
// the next binary value so bin_out and gray_out always change on the same edge.
// Supports parallel load (binary or Gray), wrap or saturate at the ends, and a
// one-cycle terminal-count pulse.
// Optional build macro GRAY_COUNTER_CHECK_EN adds a sticky err output that flags
// any non-load edge on which gray_out changed in more than one bit.
module gray_counter #(
   parameter int unsigned N    = 4,
   parameter bit          WRAP = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up_dn,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         load_is_gray,
   output logic [N-1:0] bin_out,
   output logic [N-1:0] gray_out,
   output logic         tc
`ifdef GRAY_COUNTER_CHECK_EN
   ,
   output logic         err
`endif
);

   localparam logic [N-1:0] MaxVal = {N{1'b1}};
   localparam logic [N-1:0] MinVal = {N{1'b0}};
   localparam logic [N-1:0] One    = {{(N-1){1'b0}}, 1'b1};

   // Gray to binary: prefix XOR running down from the MSB.
   function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
      logic [N-1:0] b;
      b[N-1] = g[N-1];
      for (int i = int'(N) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [N-1:0] bin_q, bin_d;
   logic [N-1:0] gray_q, gray_d;
   logic         tc_q, tc_d;

   // Next-state: load beats count beats hold; tc only on boundary steps.
   always_comb begin
      bin_d = bin_q;
      tc_d  = 1'b0;
      if (load) begin
         // load_val only reaches the state through this branch, so an X on it
         // while load is low cannot leak into the count.
         bin_d = load_is_gray ? gray2bin(load_val) : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (bin_q == MaxVal) begin
               tc_d  = 1'b1;
               bin_d = WRAP ? MinVal : MaxVal;
            end else begin
               bin_d = bin_q + One;
            end
         end else begin
            if (bin_q == MinVal) begin
               tc_d  = 1'b1;
               bin_d = WRAP ? MaxVal : MinVal;
            end else begin
               bin_d = bin_q - One;
            end
         end
      end
      gray_d = bin2gray(bin_d);
   end

   // State registers; asynchronous clear of every output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= MinVal;
         gray_q <= MinVal;
         tc_q   <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         tc_q   <= tc_d;
      end
   end

   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign tc       = tc_q;

`ifdef GRAY_COUNTER_CHECK_EN
   logic [N-1:0] prev_gray_q;
   logic         last_load_q;
   logic         err_q, err_d;
   logic [N-1:0] gray_diff;
   logic         multi_bit;

   // Flag a multi-bit Gray change unless the edge that produced it was a load.
   always_comb begin
      gray_diff = gray_q ^ prev_gray_q;
      // More than one bit set iff clearing the lowest set bit leaves something.
      multi_bit = (gray_diff & (gray_diff - One)) != MinVal;
      err_d     = err_q | (multi_bit & ~last_load_q);
   end

   // Checker history and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_gray_q <= MinVal;
         last_load_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         prev_gray_q <= gray_q;
         last_load_q <= load;
         err_q       <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: one wrapping and one saturating N=4 instance, a table
// of directed vectors for the wrapping counter plus hand-written sequences.
module tb_gray_counter;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Wrapping instance signals
   logic         w_en, w_up, w_load, w_lg;
   logic [N-1:0] w_lv, w_bin, w_gray;
   logic         w_tc;
   // Saturating instance signals
   logic         s_en, s_up, s_load, s_lg;
   logic [N-1:0] s_lv, s_bin, s_gray;
   logic         s_tc;
`ifdef GRAY_COUNTER_CHECK_EN
   logic         w_err, s_err;
`endif

   gray_counter #(.N(N), .WRAP(1'b1)) u_wrap (
      .clk          (clk),
      .rst          (rst),
      .en           (w_en),
      .up_dn        (w_up),
      .load         (w_load),
      .load_val     (w_lv),
      .load_is_gray (w_lg),
      .bin_out      (w_bin),
      .gray_out     (w_gray),
      .tc           (w_tc)
`ifdef GRAY_COUNTER_CHECK_EN
      ,
      .err          (w_err)
`endif
   );

   gray_counter #(.N(N), .WRAP(1'b0)) u_sat (
      .clk          (clk),
      .rst          (rst),
      .en           (s_en),
      .up_dn        (s_up),
      .load         (s_load),
      .load_val     (s_lv),
      .load_is_gray (s_lg),
      .bin_out      (s_bin),
      .gray_out     (s_gray),
      .tc           (s_tc)
`ifdef GRAY_COUNTER_CHECK_EN
      ,
      .err          (s_err)
`endif
   );

   typedef struct {
      logic         load;
      logic [N-1:0] lv;
      logic         lg;
      logic         en;
      logic         up;
      logic [N-1:0] exp_bin;
      logic [N-1:0] exp_gray;
      logic         exp_tc;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic void addv(input logic load, input logic [N-1:0] lv, input logic lg,
                                input logic en, input logic up, input logic [N-1:0] eb,
                                input logic [N-1:0] eg, input logic et);
      vec_t v;
      v.load = load; v.lv = lv; v.lg = lg; v.en = en; v.up = up;
      v.exp_bin = eb; v.exp_gray = eg; v.exp_tc = et;
      vecs.push_back(v);
   endfunction

   task automatic drive_w(input logic load, input logic [N-1:0] lv, input logic lg,
                          input logic en, input logic up);
      w_load = load; w_lv = lv; w_lg = lg; w_en = en; w_up = up;
   endtask

   task automatic drive_s(input logic load, input logic [N-1:0] lv, input logic lg,
                          input logic en, input logic up);
      s_load = load; s_lv = lv; s_lg = lg; s_en = en; s_up = up;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check_s(input string name, input logic [N-1:0] eb,
                          input logic [N-1:0] eg, input logic et);
      check({name, ".bin"},  32'(s_bin),  32'(eb));
      check({name, ".gray"}, 32'(s_gray), 32'(eg));
      check({name, ".tc"},   32'(s_tc),   32'(et));
   endtask

   initial begin
      logic [N-1:0] gseq [16];
      gseq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
               4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};

      // Full up-count from reset through the wrap.
      for (int i = 0; i < 16; i++) begin
         addv(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'((i + 1) % 16), gseq[i], (i == 15));
      end
      // Gray load of 1101 -> binary 9, then count down.
      addv(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 4'd9, 4'b1101, 1'b0);
      addv(1'b0, 4'd0,    1'b0, 1'b1, 1'b0, 4'd8, 4'b1100, 1'b0);
      // Load beats en; then idle hold.
      addv(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 4'd5, 4'b0111, 1'b0);
      addv(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 4'b0111, 1'b0);
      // Downward wrap, hold, then direction changes on consecutive cycles.
      addv(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b0);
      addv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd15, 4'b1000, 1'b1);
      addv(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd15, 4'b1000, 1'b0);
      addv(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0,  4'b0000, 1'b1);
      addv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd15, 4'b1000, 1'b1);
      addv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd14, 4'b1001, 1'b0);
      addv(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd15, 4'b1000, 1'b0);

      rst = 1'b1;
      drive_w(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      drive_s(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      check("reset.w.bin",  32'(w_bin),  32'd0);
      check("reset.w.gray", 32'(w_gray), 32'd0);
      check("reset.w.tc",   32'(w_tc),   32'd0);
      check_s("reset.s", 4'd0, 4'd0, 1'b0);
      rst = 1'b0;

      // Table-driven run on the wrapping counter.
      foreach (vecs[i]) begin
         drive_w(vecs[i].load, vecs[i].lv, vecs[i].lg, vecs[i].en, vecs[i].up);
         step();
         check($sformatf("vec%0d.bin", i),  32'(w_bin),  32'(vecs[i].exp_bin));
         check($sformatf("vec%0d.gray", i), 32'(w_gray), 32'(vecs[i].exp_gray));
         check($sformatf("vec%0d.tc", i),   32'(w_tc),   32'(vecs[i].exp_tc));
      end
      drive_w(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Saturating counter: pinned at top keeps tc high, then steps down.
      drive_s(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
      step();
      check_s("sat.load15", 4'd15, 4'b1000, 1'b0);
      drive_s(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_s($sformatf("sat.top%0d", i), 4'd15, 4'b1000, 1'b1);
      end
      drive_s(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      step();
      check_s("sat.down14", 4'd14, 4'b1001, 1'b0);
      // Bottom saturation, then up again.
      drive_s(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      drive_s(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         check_s($sformatf("sat.bot%0d", i), 4'd0, 4'd0, 1'b1);
      end
      drive_s(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      step();
      check_s("sat.up1", 4'd1, 4'b0001, 1'b0);
      drive_s(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-cycle while counting.
      drive_w(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      drive_w(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      repeat (7) step();
      check("arst.pre.bin", 32'(w_bin), 32'd7);
      #3;
      rst = 1'b1;
      #1;
      check("arst.bin",  32'(w_bin),  32'd0);
      check("arst.gray", 32'(w_gray), 32'd0);
      check("arst.tc",   32'(w_tc),   32'd0);
      step();
      #3;
      rst = 1'b0;
      step();
      check("arst.resume.bin",  32'(w_bin),  32'd1);
      check("arst.resume.gray", 32'(w_gray), 32'd1);
      step();
      check("arst.resume2.bin", 32'(w_bin), 32'd2);

`ifdef GRAY_COUNTER_CHECK_EN
      // Random counting without loads must never raise err.
      for (int i = 0; i < 200; i++) begin
         drive_w(1'b0, 4'd0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         drive_s(1'b0, 4'd0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         step();
      end
      check("chk.rand.w.err", 32'(w_err), 32'd0);
      check("chk.rand.s.err", 32'(s_err), 32'd0);
      // Load 0 then 10: four Gray bits flip on a load edge, which is exempt.
      drive_w(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      drive_w(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
      step();
      check("chk.load.gray", 32'(w_gray), 32'b1111);
      drive_w(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      check("chk.load.err", 32'(w_err), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
